// File: rtl/warp_dispatch_scheduler.sv
// Warp dispatch scheduler: arbitrates ready warp instructions onto registered
// dispatch ports, each restricted to a set of execution-unit types.
// Policies: round-robin (policy_i=0) and greedy-then-oldest (policy_i=1).
// Optional starvation override enabled by defining WARP_DISP_STARVATION_GUARD_EN;
// without it starve_o is tied low and the wait counters only order GTO picks.
module warp_dispatch_scheduler #(
  parameter int NumWarps      = 8,
  parameter int DispatchWidth = 2,
  parameter int DataWidth     = 64,
  parameter int NumEuTypes    = 4,
  parameter int AgeWidth      = 4,
  parameter int StarveLimit   = 12,
  parameter logic [DispatchWidth-1:0][NumEuTypes-1:0] PortEuMask = '1,
  localparam int WidWidth = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int EuWidth  = (NumEuTypes > 1) ? $clog2(NumEuTypes) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     policy_i,
  input  logic [NumWarps-1:0]                      warp_valid_i,
  input  logic [NumWarps-1:0][EuWidth-1:0]         warp_eu_type_i,
  input  logic [NumWarps-1:0][DataWidth-1:0]       warp_data_i,
  output logic [NumWarps-1:0]                      warp_ready_o,
  output logic [DispatchWidth-1:0]                 disp_valid_o,
  input  logic [DispatchWidth-1:0]                 disp_ready_i,
  output logic [DispatchWidth-1:0][WidWidth-1:0]   disp_wid_o,
  output logic [DispatchWidth-1:0][DataWidth-1:0]  disp_data_o,
  output logic [NumWarps-1:0]                      starve_o
);

  typedef enum logic [1:0] {PickNone, PickStarve, PickRr, PickGto} pick_e;

  if (StarveLimit >= (1 << AgeWidth)) begin : g_limit_check
    $error("StarveLimit must be below 2**AgeWidth");
  end

  logic [NumWarps-1:0][AgeWidth-1:0]       cnt_q;
  logic [NumWarps-1:0][AgeWidth-1:0]       cnt_d;
  logic [NumWarps-1:0]                     starving;
  logic [NumWarps-1:0]                     taken;
  logic [DispatchWidth-1:0]                port_open;
  logic [DispatchWidth-1:0]                gr_valid_q;
  logic [DispatchWidth-1:0][WidWidth-1:0]  rr_ptr_q;
  logic [DispatchWidth-1:0][WidWidth-1:0]  gr_wid_q;
  logic [DispatchWidth-1:0][WidWidth-1:0]  pick_wid;
  logic [DispatchWidth-1:0][NumWarps-1:0]  elig;
  pick_e                                   pick_kind [DispatchWidth];

  assign port_open    = ~disp_valid_o | disp_ready_i;
  assign warp_ready_o = taken;

  // Resolve ports in index order; a warp taken by a lower port is invisible to higher ones.
  always_comb begin : arb
    logic                type_ok;
    logic                found;
    logic [AgeWidth-1:0] best_age;
    int unsigned         idx;
    taken    = '0;
    elig     = '0;
    pick_wid = '0;
    type_ok  = 1'b0;
    found    = 1'b0;
    best_age = '0;
    idx      = 0;
    for (int unsigned p = 0; p < DispatchWidth; p++) begin
      pick_kind[p] = PickNone;
    end
    for (int unsigned p = 0; p < DispatchWidth; p++) begin
      for (int unsigned w = 0; w < NumWarps; w++) begin
        type_ok = 1'b0;
        for (int unsigned t = 0; t < NumEuTypes; t++) begin
          if (warp_eu_type_i[w] == EuWidth'(t) && PortEuMask[p][t]) type_ok = 1'b1;
        end
        elig[p][w] = warp_valid_i[w] && type_ok && !taken[w];
      end
      found    = 1'b0;
      best_age = '0;
      if (port_open[p]) begin
        for (int unsigned w = 0; w < NumWarps; w++) begin
          if (!found && elig[p][w] && starving[w]) begin
            pick_wid[p]  = WidWidth'(w);
            pick_kind[p] = PickStarve;
            found        = 1'b1;
          end
        end
        if (!found && !policy_i) begin
          for (int unsigned k = 1; k <= NumWarps; k++) begin
            idx = (32'(rr_ptr_q[p]) + k) % NumWarps;
            if (!found && elig[p][idx]) begin
              pick_wid[p]  = WidWidth'(idx);
              pick_kind[p] = PickRr;
              found        = 1'b1;
            end
          end
        end
        if (!found && policy_i) begin
          if (gr_valid_q[p] && elig[p][gr_wid_q[p]]) begin
            pick_wid[p]  = gr_wid_q[p];
            pick_kind[p] = PickGto;
            found        = 1'b1;
          end else begin
            for (int unsigned w = 0; w < NumWarps; w++) begin
              if (elig[p][w] && (!found || cnt_q[w] > best_age)) begin
                best_age     = cnt_q[w];
                pick_wid[p]  = WidWidth'(w);
                pick_kind[p] = PickGto;
                found        = 1'b1;
              end
            end
          end
        end
      end
      if (found) taken[pick_wid[p]] = 1'b1;
    end
  end

  // Wait counters: cleared on grant or idle, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned w = 0; w < NumWarps; w++) begin
      if (taken[w] || !warp_valid_i[w]) begin
        cnt_d[w] = '0;
      end else if (cnt_q[w] != '1) begin
        cnt_d[w] = cnt_q[w] + AgeWidth'(1);
      end
    end
  end

  // Arbitration state: counters, RR pointers, greedy wid per port.
  // Greedy state is only meaningful under GTO, so holding it clear while in RR
  // also gives the "cleared on policy change" behaviour without tracking the old policy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      gr_valid_q <= '0;
      gr_wid_q   <= '0;
      for (int unsigned p = 0; p < DispatchWidth; p++) begin
        rr_ptr_q[p] <= WidWidth'(NumWarps - 1);
      end
    end else begin
      cnt_q <= cnt_d;
      for (int unsigned p = 0; p < DispatchWidth; p++) begin
        if (!policy_i) begin
          gr_valid_q[p] <= 1'b0;
          if (pick_kind[p] != PickNone) rr_ptr_q[p] <= pick_wid[p];
        end else if (pick_kind[p] == PickGto) begin
          gr_wid_q[p]   <= pick_wid[p];
          gr_valid_q[p] <= 1'b1;
        end else begin
          gr_valid_q[p] <= gr_valid_q[p] && warp_valid_i[gr_wid_q[p]];
        end
      end
    end
  end

  // Output port registers: load on grant when open, hold under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      disp_valid_o <= '0;
      disp_wid_o   <= '0;
      disp_data_o  <= '0;
    end else begin
      for (int unsigned p = 0; p < DispatchWidth; p++) begin
        if (port_open[p]) begin
          disp_valid_o[p] <= (pick_kind[p] != PickNone);
          if (pick_kind[p] != PickNone) begin
            disp_wid_o[p]  <= pick_wid[p];
            disp_data_o[p] <= warp_data_i[pick_wid[p]];
          end
        end
      end
    end
  end

`ifdef WARP_DISP_STARVATION_GUARD_EN
  localparam logic [AgeWidth-1:0] StarveVal = AgeWidth'(StarveLimit);

  // Combinational starve check on the current counters.
  always_comb begin
    starving = '0;
    for (int unsigned w = 0; w < NumWarps; w++) begin
      starving[w] = (cnt_q[w] >= StarveVal);
    end
  end

  // Registered starve flags track the counters after each edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_o <= '0;
    end else begin
      for (int unsigned w = 0; w < NumWarps; w++) begin
        starve_o[w] <= (cnt_d[w] >= StarveVal);
      end
    end
  end
`else
  assign starving = '0;
  assign starve_o = '0;
`endif

endmodule

// File: tb/tb_warp_dispatch_scheduler.sv
// Self-checking bench for warp_dispatch_scheduler: directed scenarios plus a
// randomized run, all checked against a behavioural model of the issue rules.
// Port masks: p0 takes types {0,2}, p1 takes {0,1}, p2 has an empty mask.
module tb_warp_dispatch_scheduler;
  localparam int NW = 8;
  localparam int DW = 3;
  localparam int SL = 12;
  localparam int AGE_MAX = 15;
  localparam logic [DW-1:0][3:0] MASK = 12'b0000_0011_0101;
`ifdef WARP_DISP_STARVATION_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   policy = 1'b0;
  logic [NW-1:0]          wvalid = '0;
  logic [NW-1:0][1:0]     wtype = '0;
  logic [NW-1:0][63:0]    wdata = '0;
  logic [NW-1:0]          wready;
  logic [DW-1:0]          dvalid;
  logic [DW-1:0]          dready = '1;
  logic [DW-1:0][2:0]     dwid;
  logic [DW-1:0][63:0]    ddata;
  logic [NW-1:0]          starve;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          m_cnt  [NW];
  int          m_rr   [DW];
  int          m_gw   [DW];
  bit          m_gv   [DW];
  bit          m_val  [DW];
  int          m_wid  [DW];
  logic [63:0] m_data [DW];
  int          pk_kind[DW];   // 0 none, 1 starving, 2 round-robin, 3 gto
  int          pk_w   [DW];
  logic [NW-1:0] exp_ready;

  warp_dispatch_scheduler #(
    .NumWarps(NW), .DispatchWidth(DW), .DataWidth(64), .NumEuTypes(4),
    .AgeWidth(4), .StarveLimit(SL), .PortEuMask(MASK)
  ) dut (
    .clk_i(clk), .rst_i(rst), .policy_i(policy),
    .warp_valid_i(wvalid), .warp_eu_type_i(wtype), .warp_data_i(wdata),
    .warp_ready_o(wready), .disp_valid_o(dvalid), .disp_ready_i(dready),
    .disp_wid_o(dwid), .disp_data_o(ddata), .starve_o(starve)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic bit allows(int p, int t);
    case (p)
      0:       return (t == 0) || (t == 2);
      1:       return (t == 0) || (t == 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NW; w++) m_cnt[w] = 0;
    for (int p = 0; p < DW; p++) begin
      m_rr[p] = NW - 1; m_gw[p] = 0; m_gv[p] = 0;
      m_val[p] = 0; m_wid[p] = 0; m_data[p] = '0;
    end
  endtask

  // Expected grants for the current inputs and model state.
  task automatic model_eval();
    int c[$];
    int bestd, best, d;
    bit hit;
    exp_ready = '0;
    for (int p = 0; p < DW; p++) begin
      pk_kind[p] = 0; pk_w[p] = 0;
      if (m_val[p] && !dready[p]) continue;
      c.delete();
      for (int w = 0; w < NW; w++)
        if (wvalid[w] && allows(p, int'(wtype[w])) && !exp_ready[w]) c.push_back(w);
      if (c.size() == 0) continue;
      if (GUARD)
        foreach (c[i]) if (pk_kind[p] == 0 && m_cnt[c[i]] >= SL) begin pk_kind[p] = 1; pk_w[p] = c[i]; end
      if (pk_kind[p] == 0 && !policy) begin
        bestd = NW;
        foreach (c[i]) begin
          d = (c[i] - m_rr[p] - 1 + 2 * NW) % NW;
          if (d < bestd) begin bestd = d; pk_w[p] = c[i]; end
        end
        pk_kind[p] = 2;
      end else if (pk_kind[p] == 0) begin
        hit = 0;
        if (m_gv[p]) foreach (c[i]) if (c[i] == m_gw[p]) hit = 1;
        if (hit) pk_w[p] = m_gw[p];
        else begin
          best = -1;
          foreach (c[i]) if (m_cnt[c[i]] > best) begin best = m_cnt[c[i]]; pk_w[p] = c[i]; end
        end
        pk_kind[p] = 3;
      end
      exp_ready[pk_w[p]] = 1'b1;
    end
  endtask

  // Advance the model across a clock edge using the inputs seen at that edge.
  task automatic model_commit();
    for (int w = 0; w < NW; w++) begin
      if (exp_ready[w] || !wvalid[w]) m_cnt[w] = 0;
      else if (m_cnt[w] < AGE_MAX) m_cnt[w]++;
    end
    for (int p = 0; p < DW; p++) begin
      if (!m_val[p] || dready[p]) begin
        m_val[p] = (pk_kind[p] != 0);
        if (pk_kind[p] != 0) begin m_wid[p] = pk_w[p]; m_data[p] = wdata[pk_w[p]]; end
      end
      if (!policy) begin
        m_gv[p] = 0;
        if (pk_kind[p] != 0) m_rr[p] = pk_w[p];
      end else if (pk_kind[p] == 3) begin
        m_gw[p] = pk_w[p]; m_gv[p] = 1;
      end else begin
        m_gv[p] = m_gv[p] && wvalid[m_gw[p]];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model_commit();
  endtask

  task automatic new_data();
    for (int w = 0; w < NW; w++) wdata[w] = {$urandom(), $urandom()};
  endtask

  task automatic do_reset();
    wvalid = '0; dready = '1; policy = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    if (dvalid !== '0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dvalid); end
    total++;
    if (dwid !== '0) begin bad++; $display("FAIL reset_wid got=%h exp=0", dwid); end
    total++;
    if (ddata !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", ddata); end
    total++;
    if (starve !== '0) begin bad++; $display("FAIL reset_starve got=%b exp=0", starve); end
    total++;
    @(posedge clk); #1;
    if (wready !== '0) begin bad++; $display("FAIL reset_ready got=%b exp=0", wready); end
    total++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_rr();
    logic [NW-1:0] seen, hand;
    do_reset();
    wvalid = 8'h0F; wtype = '0; seen = '0;
    for (int k = 0; k < 6; k++) begin
      new_data(); #1; model_eval();
      hand = '0; hand[k % 4] = 1'b1; hand[(k + 1) % 4] = 1'b1;
      if (wready !== hand) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", k, wready, hand); end
      total++;
      if (wready !== exp_ready) begin bad++; $display("FAIL rr_model cyc=%0d got=%b exp=%b", k, wready, exp_ready); end
      total++;
      seen |= wready;
      tick();
      if (dvalid !== 3'b011 || dwid[0] !== 3'(k % 4) || dwid[1] !== 3'((k + 1) % 4)) begin
        bad++; $display("FAIL rr_ports cyc=%0d valid=%b wid0=%0d wid1=%0d exp wid0=%0d wid1=%0d", k, dvalid, dwid[0], dwid[1], k % 4, (k + 1) % 4);
      end
      total++;
      if (ddata[0] !== m_data[0] || ddata[1] !== m_data[1]) begin
        bad++; $display("FAIL rr_data cyc=%0d got=%h/%h exp=%h/%h", k, ddata[0], ddata[1], m_data[0], m_data[1]);
      end
      total++;
      if (k == 3) begin
        if (seen !== 8'h0F) begin bad++; $display("FAIL rr_coverage got=%b exp=00001111", seen); end
        total++;
      end
    end
  endtask

  task automatic test_mask();
    do_reset();
    wvalid = 8'b0010_1010; wtype = '0;
    wtype[3] = 2'd1; wtype[5] = 2'd0; wtype[1] = 2'd3;
    for (int k = 0; k < 4; k++) begin
      new_data(); #1; model_eval();
      if (wready !== 8'b0010_1000) begin bad++; $display("FAIL mask_ready cyc=%0d got=%b exp=00101000", k, wready); end
      total++;
      tick();
      if (dvalid !== 3'b011 || dwid[0] !== 3'd5 || dwid[1] !== 3'd3) begin
        bad++; $display("FAIL mask_ports cyc=%0d valid=%b wid0=%0d wid1=%0d exp 011/5/3", k, dvalid, dwid[0], dwid[1]);
      end
      total++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    do_reset();
    wvalid = '1; wtype = '0;
    new_data(); #1; model_eval();
    held = wdata[0];
    tick();
    dready = 3'b110;
    for (int k = 0; k < 5; k++) begin
      new_data(); #1; model_eval();
      if ($countones(wready) != 1 || wready !== exp_ready) begin
        bad++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", k, wready, exp_ready);
      end
      total++;
      tick();
      if (dvalid[0] !== 1'b1 || dwid[0] !== 3'd0 || ddata[0] !== held) begin
        bad++; $display("FAIL bp_hold cyc=%0d valid=%b wid=%0d data=%h exp 1/0/%h", k, dvalid[0], dwid[0], ddata[0], held);
      end
      total++;
      if (dvalid[1] !== 1'b1 || dwid[1] !== 3'(m_wid[1]) || ddata[1] !== m_data[1]) begin
        bad++; $display("FAIL bp_p1 cyc=%0d wid=%0d exp=%0d", k, dwid[1], m_wid[1]);
      end
      total++;
    end
    dready = '1;
    new_data(); #1; model_eval();
    if (wready !== exp_ready) begin bad++; $display("FAIL bp_release got=%b exp=%b", wready, exp_ready); end
    total++;
    tick();
    if (dwid[0] !== 3'(m_wid[0]) || ddata[0] !== m_data[0]) begin
      bad++; $display("FAIL bp_reload wid=%0d exp=%0d", dwid[0], m_wid[0]);
    end
    total++;
  endtask

  task automatic test_gto();
    do_reset();
    policy = 1'b1; wtype = '0; wtype[2] = 2'd2; wtype[6] = 2'd2;
    for (int k = 0; k < 7; k++) begin
      wvalid = (k == 5) ? 8'h40 : 8'h44;
      new_data(); #1; model_eval();
      if (wready !== ((k >= 5) ? 8'h40 : 8'h04)) begin
        bad++; $display("FAIL gto_ready cyc=%0d got=%b exp=%b", k, wready, (k >= 5) ? 8'h40 : 8'h04);
      end
      total++;
      if (wready !== exp_ready) begin bad++; $display("FAIL gto_model cyc=%0d got=%b exp=%b", k, wready, exp_ready); end
      total++;
      tick();
      if (dvalid !== 3'b001 || dwid[0] !== ((k >= 5) ? 3'd6 : 3'd2)) begin
        bad++; $display("FAIL gto_port cyc=%0d valid=%b wid=%0d", k, dvalid, dwid[0]);
      end
      total++;
    end
  endtask

  task automatic test_starve();
    logic [NW-1:0] hand;
    do_reset();
    policy = 1'b1; wtype = '0; wtype[0] = 2'd2; wtype[7] = 2'd2;
    wvalid = 8'h81;
    for (int k = 0; k < 16; k++) begin
      new_data(); #1; model_eval();
      hand = (k == 12 && GUARD) ? 8'h80 : 8'h01;
      if (wready !== hand) begin bad++; $display("FAIL starve_ready cyc=%0d got=%b exp=%b", k, wready, hand); end
      total++;
      if (wready !== exp_ready) begin bad++; $display("FAIL starve_model cyc=%0d got=%b exp=%b", k, wready, exp_ready); end
      total++;
      tick();
      if (k <= 12 && starve[7] !== (GUARD && k == 11)) begin
        bad++; $display("FAIL starve_flag cyc=%0d got=%b exp=%b", k, starve[7], GUARD && k == 11);
      end
      if (k <= 12) total++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wvalid = '1; wtype = '0;
    for (int k = 0; k < 3; k++) begin new_data(); #1; model_eval(); tick(); end
    if (dvalid !== 3'b011) begin bad++; $display("FAIL mid_pre valid got=%b exp=011", dvalid); end
    total++;
    rst = 1'b1;
    #1;
    if (dvalid !== '0 || dwid !== '0 || ddata !== '0 || starve !== '0) begin
      bad++; $display("FAIL mid_async valid=%b wid=%h data=%h starve=%b exp all 0", dvalid, dwid, ddata, starve);
    end
    total++;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    new_data(); #1; model_eval();
    if (wready !== 8'h03 || wready !== exp_ready) begin bad++; $display("FAIL mid_first got=%b exp=00000011", wready); end
    total++;
    tick();
    if (dvalid !== 3'b011 || dwid[0] !== 3'd0 || dwid[1] !== 3'd1) begin
      bad++; $display("FAIL mid_ports valid=%b wid0=%0d wid1=%0d exp 011/0/1", dvalid, dwid[0], dwid[1]);
    end
    total++;
  endtask

  task automatic test_random();
    logic [NW-1:0] es;
    do_reset();
    for (int w = 0; w < NW; w++) wtype[w] = 2'($urandom_range(0, 3));
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 19) == 0) policy = ~policy;
      for (int w = 0; w < NW; w++) begin
        if ($urandom_range(0, 7) == 0) wvalid[w] = ~wvalid[w];
        if ($urandom_range(0, 7) == 0) wtype[w] = 2'($urandom_range(0, 3));
      end
      for (int p = 0; p < DW; p++) dready[p] = ($urandom_range(0, 3) != 0);
      new_data(); #1; model_eval();
      if (wready !== exp_ready) begin bad++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, wready, exp_ready); end
      total++;
      tick();
      for (int p = 0; p < DW; p++) begin
        if (dvalid[p] !== m_val[p] || (m_val[p] && (dwid[p] !== 3'(m_wid[p]) || ddata[p] !== m_data[p]))) begin
          bad++; $display("FAIL rand_port n=%0d p=%0d valid=%b wid=%0d data=%h exp %b/%0d/%h", n, p, dvalid[p], dwid[p], ddata[p], m_val[p], m_wid[p], m_data[p]);
        end
        total++;
      end
      for (int w = 0; w < NW; w++) es[w] = GUARD && (m_cnt[w] >= SL);
      if (starve !== es) begin bad++; $display("FAIL rand_starve n=%0d got=%b exp=%b", n, starve, es); end
      total++;
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_mask();
    test_backpressure();
    test_gto();
    test_starve();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
